// File: rtl/fpu_norm_pkg.sv
// Shared types and constants for the post-addition normalizer.
package fpu_norm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ADJUST,
    DONE
  } norm_state_t;

  localparam logic [7:0] EXP_MAX      = 8'hFF;
  localparam logic [7:0] EXP_MIN_NORM = 8'd1;
  localparam int         HIDDEN_BIT   = 23;
  localparam int         CARRY_BIT    = 24;

endpackage

// File: rtl/subtract.sv
// FPU exponent subtractor: diff = exp1 - shifted_amount, borrow flags a wrap.
module subtract #(
  parameter int W = 8
) (
  input  logic [W-1:0] exp1,
  input  logic [W-1:0] shifted_amount,
  output logic [W-1:0] diff,
  output logic         borrow
);

  assign {borrow, diff} = {1'b0, exp1} - {1'b0, shifted_amount};

endmodule

// File: rtl/fpu_norm_seq.sv
// Multi-cycle normalizer: one left shift per cycle, or a single carry right shift,
// then the shift count is taken off the exponent by the shared FPU subtractor.
module fpu_norm_seq
  import fpu_norm_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W:0]   mant_in,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              sticky_out,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);

  norm_state_t state, state_next;

  logic [MANT_W-1:0] mant;
  logic [EXP_W-1:0]  e_eff;
  logic [EXP_W-1:0]  exp_in_q;
  logic [EXP_W-1:0]  cnt;

  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mant_q;
  logic              sticky_q, zero_q, overflow_q, underflow_q;

  logic [EXP_W-1:0]  e_eff_in;
  logic [EXP_W-1:0]  exp_inc;
  logic [EXP_W-1:0]  sub_diff;
  logic              sub_borrow;
  logic              shift_stop;
  logic              shift_last;

  assign e_eff_in = (exp_in == '0) ? EXP_MIN_NORM : exp_in;
  assign exp_inc  = exp_in + EXP_W'(1);

  subtract #(.W(EXP_W)) u_subtract (
    .exp1           (e_eff),
    .shifted_amount (cnt),
    .diff           (sub_diff),
    .borrow         (sub_borrow)
  );

  // shift_last looks one shift ahead so the final shift lands directly in ADJUST.
  assign shift_stop = mant[HIDDEN_BIT] || (sub_diff <= EXP_MIN_NORM);
  assign shift_last = mant[HIDDEN_BIT-1] || (sub_diff <= (EXP_MIN_NORM + EXP_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (mant_in == '0 || mant_in[CARRY_BIT]) begin
            state_next = DONE;
          end else if (mant_in[HIDDEN_BIT] || e_eff_in <= EXP_MIN_NORM) begin
            state_next = ADJUST;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (shift_stop || shift_last) begin
          state_next = ADJUST;
        end
      end
      ADJUST: state_next = DONE;
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    out_valid  = (state == DONE);
    exp_out    = exp_q;
    mant_out   = mant_q;
    sticky_out = sticky_q;
    zero       = zero_q;
    overflow   = overflow_q;
    underflow  = underflow_q;
  end

  // Result registers are fully rewritten on every entry into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mant        <= '0;
      e_eff       <= '0;
      exp_in_q    <= '0;
      cnt         <= '0;
      exp_q       <= '0;
      mant_q      <= '0;
      sticky_q    <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mant     <= mant_in[MANT_W-1:0];
            e_eff    <= e_eff_in;
            exp_in_q <= exp_in;
            cnt      <= '0;
            if (mant_in == '0) begin
              exp_q       <= '0;
              mant_q      <= '0;
              sticky_q    <= 1'b0;
              zero_q      <= 1'b1;
              overflow_q  <= 1'b0;
              underflow_q <= 1'b0;
            end else if (mant_in[CARRY_BIT]) begin
              zero_q      <= 1'b0;
              underflow_q <= 1'b0;
              if (exp_inc == EXP_MAX) begin
                exp_q      <= EXP_MAX;
                mant_q     <= '0;
                sticky_q   <= 1'b0;
                overflow_q <= 1'b1;
              end else begin
                exp_q      <= exp_inc;
                mant_q     <= mant_in[CARRY_BIT:1];
                sticky_q   <= mant_in[0];
                overflow_q <= 1'b0;
              end
            end
          end
        end
        SHIFT: begin
          if (!shift_stop) begin
            mant <= mant << 1;
            cnt  <= cnt + EXP_W'(1);
          end
        end
        ADJUST: begin
          assert (!sub_borrow);
          mant_q     <= mant;
          sticky_q   <= 1'b0;
          zero_q     <= 1'b0;
          overflow_q <= 1'b0;
          if (mant[HIDDEN_BIT]) begin
            exp_q       <= sub_diff;
            underflow_q <= 1'b0;
          end else begin
            exp_q       <= '0;
            underflow_q <= (cnt != '0) || (exp_in_q > EXP_MIN_NORM);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_norm_seq.sv
// Self-checking bench for fpu_norm_seq: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_fpu_norm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  exp_in;
  logic [24:0] mant_in;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [23:0] mant_out;
  logic        sticky_out;
  logic        zero;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  e;
    logic [23:0] m;
    logic        s;
    logic        z;
    logic        o;
    logic        u;
    int          lat;
  } res_t;

  always #5 clk = ~clk;

  fpu_norm_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .exp_in     (exp_in),
    .mant_in    (mant_in),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exp_out    (exp_out),
    .mant_out   (mant_out),
    .sticky_out (sticky_out),
    .zero       (zero),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // Normalization rules in plain integer arithmetic.
  function automatic res_t refModel(input int e, input int m);
    res_t r;
    int   eeff;
    int   k;
    int   mm;
    r.e = 8'd0; r.m = 24'd0; r.s = 1'b0; r.z = 1'b0; r.o = 1'b0; r.u = 1'b0; r.lat = 1;
    if (m == 0) begin
      r.z = 1'b1;
    end else if (m >= 32'h1000000) begin
      if (e + 1 == 255) begin
        r.e = 8'hFF;
        r.o = 1'b1;
      end else begin
        r.e = 8'(e + 1);
        r.m = 24'(m / 2);
        r.s = 1'(m % 2);
      end
    end else begin
      eeff = (e == 0) ? 1 : e;
      k    = 0;
      mm   = m;
      while (mm < 32'h800000 && eeff - k > 1) begin
        mm = mm * 2;
        k  = k + 1;
      end
      if (mm >= 32'h800000) begin
        r.e = 8'(eeff - k);
      end else begin
        r.u = (k > 0) || (e > 1);
      end
      r.m   = 24'(mm);
      r.lat = k + 2;
    end
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_busy"},      32'(busy),       32'd0);
    checkVal({tag, "_out_valid"}, 32'(out_valid),  32'd0);
    checkVal({tag, "_exp_out"},   32'(exp_out),    32'd0);
    checkVal({tag, "_mant_out"},  32'(mant_out),   32'd0);
    checkVal({tag, "_sticky"},    32'(sticky_out), 32'd0);
    checkVal({tag, "_zero"},      32'(zero),       32'd0);
    checkVal({tag, "_overflow"},  32'(overflow),   32'd0);
    checkVal({tag, "_underflow"}, 32'(underflow),  32'd0);
  endtask

  // Presents one start pulse and counts edges until out_valid, bounded.
  task automatic applyStimulus(input logic [7:0] e, input logic [24:0] m, output int lat);
    @(negedge clk);
    start   = 1'b1;
    exp_in  = e;
    mant_in = m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkResult(input string tag, input res_t r, input int lat);
    checkVal({tag, "_latency"},   32'(lat),       32'(r.lat));
    checkVal({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    checkVal({tag, "_busy"},      32'(busy),      32'd1);
    checkVal({tag, "_exp_out"},   32'(exp_out),   32'(r.e));
    checkVal({tag, "_mant_out"},  32'(mant_out),  32'(r.m));
    if (!r.o) checkVal({tag, "_sticky"}, 32'(sticky_out), 32'(r.s));
    checkVal({tag, "_zero"},      32'(zero),      32'(r.z));
    checkVal({tag, "_overflow"},  32'(overflow),  32'(r.o));
    checkVal({tag, "_underflow"}, 32'(underflow), 32'(r.u));
  endtask

  task automatic checkOutput(input string tag, input res_t r, input int lat);
    checkResult(tag, r, lat);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkVal({tag, "_accept_valid"}, 32'(out_valid), 32'd0);
    checkVal({tag, "_accept_busy"},  32'(busy),      32'd0);
  endtask

  task automatic runOp(input string tag, input logic [7:0] e, input logic [24:0] m);
    int   lat;
    res_t r;
    r = refModel(int'(e), int'(m));
    applyStimulus(e, m, lat);
    checkOutput(tag, r, lat);
  endtask

  initial begin
    int          lat;
    int          sel;
    int          pos;
    logic [7:0]  e;
    logic [24:0] m;
    res_t        r;

    rst       = 1'b1;
    start     = 1'b0;
    exp_in    = 8'd0;
    mant_in   = 25'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    runOp("norm_2shift", 8'h85, 25'h0200000);
    runOp("carry",       8'h7F, 25'h1800001);
    runOp("overflow",    8'hFE, 25'h1000000);
    runOp("zero",        8'h40, 25'h0000000);
    runOp("denormal",    8'h03, 25'h0000100);
    runOp("max_shift",   8'hC0, 25'h0000001);
    runOp("exp0_nozero", 8'h00, 25'h0000100);

    // Back-pressure: outputs hold while start pulses are offered and must be ignored.
    r = refModel(8'h85, 25'h0200000);
    applyStimulus(8'h85, 25'h0200000, lat);
    checkResult("bp_first", r, lat);
    for (int i = 0; i < 5; i++) begin
      start   = 1'b1;
      exp_in  = 8'h10;
      mant_in = 25'h1000000;
      @(posedge clk);
      @(negedge clk);
      checkResult("bp_hold", r, r.lat);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    checkVal("bp_accept_valid", 32'(out_valid), 32'd0);
    checkVal("bp_accept_busy",  32'(busy),      32'd0);
    @(posedge clk);
    @(negedge clk);
    checkVal("bp_start_ignored", 32'(busy), 32'd0);

    // Reset during the third SHIFT cycle of a ten-shift operation.
    start   = 1'b1;
    exp_in  = 8'h90;
    mant_in = 25'h0002000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkVal("mid_shift_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkReset("rst_shift");
    rst = 1'b0;
    runOp("after_rst", 8'h90, 25'h0002000);

    // Reset wins over an accept in DONE.
    applyStimulus(8'h7F, 25'h1800001, lat);
    checkVal("rst_done_valid", 32'(out_valid), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkReset("rst_done");
    rst       = 1'b0;
    out_ready = 1'b0;

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      e   = (sel < 3) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 254));
      if (sel == 9) begin
        m = 25'd0;
      end else if (sel == 8) begin
        m = 25'h1000000 | 25'($urandom_range(0, 24'hFFFFFF));
        if ($urandom_range(0, 3) == 0) e = 8'hFE;
      end else begin
        pos = $urandom_range(0, 23);
        m   = 25'((($urandom) & ((32'd1 << pos) - 32'd1)) | (32'd1 << pos));
      end
      runOp("random", e, m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_norm_seq.md
# fpu_norm_seq

Multi-cycle post-addition normalizer for the single-precision FPU. Takes the raw exponent and the 25-bit carry-extended mantissa from the add/subtract datapath and produces a normalized mantissa. Leading zeros are removed one left shift per cycle, and a leading carry with one right shift. The accumulated shift count is then applied to the exponent through the FPU's 8-bit exponent subtractor. The block sits between mantissa add and the rounding stage, with a start/busy handshake in and a valid/ready handshake out.

## Interface
- `EXP_W`, default 8: exponent width.
- `MANT_W`, default 24: mantissa width, including the hidden bit.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request. Sampled only in IDLE.
- `exp_in` in EXP_W: biased exponent of the unnormalized result.
- `mant_in` in MANT_W+1: bit 24 is the carry, bit 23 is the hidden-bit position.
- `busy` out 1: high whenever the state is not IDLE.
- `out_valid` out 1: result valid. Held until accepted.
- `out_ready` in 1: downstream accept.
- `exp_out` out EXP_W: normalized biased exponent.
- `mant_out` out MANT_W: normalized mantissa; bit 23 is the hidden bit.
- `sticky_out` out 1: bit lost by a carry right shift.
- `zero`, `overflow`, `underflow` out 1 each: result class flags.

## Operation
- States: IDLE, SHIFT, ADJUST, DONE.
- Effective exponent `e_eff = (exp_in == 0) ? 1 : exp_in`. It is latched at start together with the mantissa; the shift count `cnt` (8-bit) is cleared.
- IDLE with `start`, priority order:
  - `mant_in == 0` → DONE with `exp_out = 0`, `mant_out = 0`, `zero = 1`.
  - `mant_in[24] == 1`:
    - Result is `mant_out = mant_in[24:1]`, `sticky_out = mant_in[0]`, `exp_out = exp_in + 1`.
    - If `exp_in + 1 == 8'hFF`: instead `exp_out = 8'hFF`, `mant_out = 0`, `overflow = 1`.
    - Next state is DONE.
  - Otherwise → SHIFT.
- SHIFT, each cycle:
  - If `mant[23] == 1` or `e_eff - cnt <= 1` → ADJUST.
  - Else `mant <<= 1`, `cnt += 1`.
- ADJUST (one cycle): the subtractor computes `e_eff - cnt`.
  - If `mant[23] == 1`: `exp_out = e_eff - cnt`.
  - Else: `exp_out = 0` (denormal), with `underflow = 1` if `cnt > 0` or `exp_in > 1`.
  - Next state is DONE.
- DONE: `out_valid = 1` and all outputs are stable.
  - `out_ready` → IDLE on that edge.
  - `start` is ignored while `busy` is high (no queueing).
- Subtraction never borrows: `cnt <= e_eff - 1` by construction. A borrow is a design error; assert it in simulation.
- The left-shift limit keeps the exponent at or above 1, so IEEE denormals come out with `exp_out = 0` and the mantissa scaled by 2^-126.

## Timing
- Reset: state IDLE; `busy`, `out_valid`, `zero`, `overflow`, `underflow`, `sticky_out` = 0; `exp_out` = 0; `mant_out` = 0.
- Reset wins over every other event, including mid-SHIFT and DONE-with-`out_ready`.
- Latency, counted from the edge that samples `start` to `out_valid` high:
  - Zero, carry and overflow cases: 1 cycle.
  - k left shifts: k+2 cycles.
  - Maximum: 25 cycles (k = 23).
- Throughput: one operation per latency+1 cycles at best, since DONE → IDLE costs the accept edge.
- `start` in the same cycle as DONE+`out_ready` is ignored. It must be re-presented in IDLE.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `fpu_norm_pkg`:
  - `norm_state_t` enum (IDLE, SHIFT, ADJUST, DONE).
  - Constants `EXP_MAX = 8'hFF`, `EXP_MIN_NORM = 8'd1`, `HIDDEN_BIT = 23`, `CARRY_BIT = 24`.
- One sub-module: the existing FPU `subtract` exponent subtractor (8-bit, `exp1 - shifted_amount`), instantiated once with `exp1 = e_eff`, `shifted_amount = cnt`. Its result is registered in ADJUST.
- The `+1` carry path uses a local incrementer and does not share the subtractor.

## Test plan
- `exp_in=8'h85`, `mant_in=25'h0200000` → after 4 cycles: `exp_out=8'h83`, `mant_out=24'h800000`, flags 0.
- `exp_in=8'h7F`, `mant_in=25'h1800001` → after 1 cycle: `exp_out=8'h80`, `mant_out=24'hC00000`, `sticky_out=1`.
- `exp_in=8'hFE`, `mant_in=25'h1000000` → `exp_out=8'hFF`, `mant_out=0`, `overflow=1`; then `exp_in=8'h40`, `mant_in=0` → `zero=1`, 1 cycle.
- `exp_in=8'h03`, `mant_in=25'h0000100` → 2 shifts, after 4 cycles: `exp_out=0`, `mant_out=24'h000400`, `underflow=1`.
- Back-pressure: hold `out_ready=0` for 5 cycles → outputs stable, `busy=1`, extra `start` pulses ignored. Then `out_ready=1` → IDLE the next edge.
- Assert `rst` on the 3rd SHIFT cycle of a k=10 operation → next edge all outputs at reset values. A following `start` completes normally.
